ram_latency_model: RTL and testbench

//  Synthesisable word-addressed RAM responder for the RAM side of memory_control:
//  it accepts ramREN/ramWEN/ramaddr/ramstore and answers with ramstate/ramload.
//  It replaces the vendor RAM in unit benches and gives a programmable access latency,
//  so arbitration and wait logic in memory_control is exercised deterministically.

---
 rtl/ram_latency_model.sv | 153 +++++++++++++++
 tb/tb_ram_latency_model.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_latency_model.sv
// ram_latency_model: word-addressed RAM responder with a programmable access
// latency. It answers ramREN/ramWEN requests with ramstate FREE/BUSY/ACCESS/ERROR
// so that memory_control arbitration and wait logic can be exercised
// deterministically. The storage array has no reset; only the control state does.
module ram_latency_model #(
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 16384
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    input  logic        ramREN,
    input  logic        ramWEN,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    // ramstate encoding seen by memory_control
    localparam logic [1:0] FREE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] ACCESS = 2'b10;
    localparam logic [1:0] ERROR  = 2'b11;

    // internal sequencing states
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_WAIT = 2'b01;
    localparam logic [1:0] S_ACC  = 2'b10;

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LAT == 0 ? 0 : LAT - 1);

    logic [31:0] mem [DEPTH];

    logic [1:0]  state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [29:0] req_addr, req_addr_nxt;
    logic        req_wen, req_wen_nxt;

    logic [29:0] word;
    logic        in_range;
    logic        req_err;
    logic        req_vld;
    logic        req_changed;
    logic        do_write;
    logic        do_read;

    // The byte offset within a word is deliberately ignored.
    logic unused_byte_ofs;
    assign unused_byte_ofs = ^ramaddr[1:0];

    assign word        = ramaddr[31:2];
    assign in_range    = (32'(word) < DEPTH);
    assign req_err     = (ramREN && ramWEN) || ((ramREN || ramWEN) && !in_range);
    assign req_vld     = (ramREN ^ ramWEN) && in_range;
    assign req_changed = (word != req_addr) || (ramWEN != req_wen);

    // Next-state, response and capture decode; an error overrides every state.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        req_addr_nxt = req_addr;
        req_wen_nxt  = req_wen;
        ramstate     = FREE;
        do_write     = 1'b0;
        do_read      = 1'b0;
        if (req_err) begin
            ramstate  = ERROR;
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_WAIT: begin
                    if (!req_vld) begin
                        ramstate  = FREE;
                        state_nxt = S_IDLE;
                    end else if (req_changed) begin
                        // New address or direction: restart the latency count.
                        ramstate     = BUSY;
                        req_addr_nxt = word;
                        req_wen_nxt  = ramWEN;
                        cnt_nxt      = CNT_INIT;
                    end else begin
                        ramstate = BUSY;
                        if (cnt == 4'd0) begin
                            state_nxt = S_ACC;
                        end else begin
                            cnt_nxt = cnt - 4'd1;
                        end
                    end
                end
                S_ACC: begin
                    // Single ACCESS cycle; a request altered here is not served.
                    state_nxt = S_IDLE;
                    if (req_vld && !req_changed) begin
                        ramstate = ACCESS;
                        do_write = ramWEN;
                        do_read  = ramREN;
                    end else if (req_vld) begin
                        ramstate = BUSY;
                    end else begin
                        ramstate = FREE;
                    end
                end
                default: begin
                    if (req_vld) begin
                        ramstate     = BUSY;
                        req_addr_nxt = word;
                        req_wen_nxt  = ramWEN;
                        if (LAT == 0) begin
                            state_nxt = S_ACC;
                        end else begin
                            state_nxt = S_WAIT;
                            cnt_nxt   = CNT_INIT;
                        end
                    end else begin
                        ramstate = FREE;
                    end
                end
            endcase
        end
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            req_addr <= 30'd0;
            req_wen  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            req_addr <= req_addr_nxt;
            req_wen  <= req_wen_nxt;
        end
    end

    // Storage array: the write commits at the edge closing the ACCESS cycle.
    always_ff @(posedge CLK) begin
        if (do_write) begin
            mem[word[AW-1:0]] <= ramstore;
        end
    end

    // Read data is driven only during a read ACCESS cycle.
    always_comb begin
        ramload = 32'h0;
        if (do_read) begin
            ramload = mem[word[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_ram_latency_model.sv
// Directed bench for ram_latency_model: one instance built with LAT=2 and one
// with LAT=0, both on the same clock and reset.
module tb_ram_latency_model;

    localparam logic [1:0] FREE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] ACCESS = 2'b10;
    localparam logic [1:0] ERROR  = 2'b11;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] addr, store, load;
    logic        ren, wen;
    logic [1:0]  rstate;
    logic [31:0] addr0, store0, load0;
    logic        ren0, wen0;
    logic [1:0]  rstate0;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ram_latency_model #(.LAT(2), .DEPTH(16384)) u_dut (
        .CLK(CLK), .nRST(nRST), .ramaddr(addr), .ramstore(store),
        .ramREN(ren), .ramWEN(wen), .ramload(load), .ramstate(rstate)
    );

    ram_latency_model #(.LAT(0), .DEPTH(16384)) u_dut0 (
        .CLK(CLK), .nRST(nRST), .ramaddr(addr0), .ramstore(store0),
        .ramREN(ren0), .ramWEN(wen0), .ramload(load0), .ramstate(rstate0)
    );

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Full LAT=2 write on u_dut, starting and ending with the block idle.
    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        wen = 1'b1; addr = a; store = d;
        repeat (4) next_cycle();
        wen = 1'b0; store = 32'h0;
    endtask

    // Full LAT=2 read on u_dut; returns what is seen in the ACCESS cycle.
    task automatic read_word(input logic [31:0] a, output logic [31:0] d, output logic [1:0] st);
        ren = 1'b1; addr = a;
        repeat (3) next_cycle();
        @(negedge CLK);
        d = load; st = rstate;
        next_cycle();
        ren = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b1; ren = 1'b1; wen = 1'b0; addr = 32'h10; store = 32'h0;
        ren0 = 1'b0; wen0 = 1'b0; addr0 = 32'h0; store0 = 32'h0;
        #2 nRST = 1'b0;
        #1 ren = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            checks++;
            if (rstate !== FREE) begin errors++; $display("FAIL reset_state cyc=%0d got=%b exp=%b", c, rstate, FREE); end
            checks++;
            if (load !== 32'h0) begin errors++; $display("FAIL reset_load got=%h exp=0", load); end
            checks++;
            if (rstate0 !== FREE) begin errors++; $display("FAIL reset_state_lat0 got=%b exp=%b", rstate0, FREE); end
            next_cycle();
        end
        nRST = 1'b1;
        @(negedge CLK);
        checks++;
        if (rstate !== FREE) begin errors++; $display("FAIL reset_release got=%b exp=%b", rstate, FREE); end
        next_cycle();
    endtask

    task automatic test_write_read();
        logic [1:0] exp_st;
        wen = 1'b1; addr = 32'hF0; store = 32'hDAD1DAD1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            exp_st = (c == 3) ? ACCESS : BUSY;
            checks++;
            if (rstate !== exp_st) begin errors++; $display("FAIL write_state cyc=%0d got=%b exp=%b", c, rstate, exp_st); end
            checks++;
            if (load !== 32'h0) begin errors++; $display("FAIL write_load cyc=%0d got=%h exp=0", c, load); end
            next_cycle();
        end
        wen = 1'b0; store = 32'h0;
        ren = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            exp_st = (c == 3) ? ACCESS : BUSY;
            checks++;
            if (rstate !== exp_st) begin errors++; $display("FAIL read_state cyc=%0d got=%b exp=%b", c, rstate, exp_st); end
            checks++;
            if (load !== ((c == 3) ? 32'hDAD1DAD1 : 32'h0)) begin errors++; $display("FAIL read_load cyc=%0d got=%h", c, load); end
            next_cycle();
        end
        ren = 1'b0;
        @(negedge CLK);
        checks++;
        if (rstate !== FREE) begin errors++; $display("FAIL after_read got=%b exp=%b", rstate, FREE); end
        next_cycle();
    endtask

    task automatic test_byte_offset();
        logic [31:0] d;
        logic [1:0]  st;
        read_word(32'hF3, d, st);
        checks++;
        if (st !== ACCESS) begin errors++; $display("FAIL byteofs_state got=%b exp=%b", st, ACCESS); end
        checks++;
        if (d !== 32'hDAD1DAD1) begin errors++; $display("FAIL byteofs_load got=%h exp=dad1dad1", d); end
    endtask

    task automatic test_restart();
        logic [1:0] exp_st;
        write_word(32'h44, 32'h1111_0044);
        write_word(32'h88, 32'h2222_0088);
        ren = 1'b1; addr = 32'h88;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) addr = 32'h44;
            @(negedge CLK);
            exp_st = (c == 4) ? ACCESS : BUSY;
            checks++;
            if (rstate !== exp_st) begin errors++; $display("FAIL restart_state cyc=%0d got=%b exp=%b", c, rstate, exp_st); end
            if (c == 4) begin
                checks++;
                if (load !== 32'h1111_0044) begin errors++; $display("FAIL restart_load got=%h exp=11110044", load); end
            end
            next_cycle();
        end
        ren = 1'b0;
    endtask

    task automatic test_drop();
        logic [31:0] d;
        logic [1:0]  st;
        logic [1:0]  exp_st;
        wen = 1'b1; addr = 32'h88; store = 32'hBAD0_0088;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) begin wen = 1'b0; store = 32'h0; end
            @(negedge CLK);
            exp_st = (c < 2) ? BUSY : FREE;
            checks++;
            if (rstate !== exp_st) begin errors++; $display("FAIL drop_state cyc=%0d got=%b exp=%b", c, rstate, exp_st); end
            next_cycle();
        end
        read_word(32'h88, d, st);
        checks++;
        if (d !== 32'h2222_0088) begin errors++; $display("FAIL drop_nowrite got=%h exp=22220088", d); end
    endtask

    task automatic test_acc_change();
        logic [31:0] d;
        logic [1:0]  st;
        wen = 1'b1; addr = 32'h88; store = 32'hDEAD_0088;
        repeat (3) next_cycle();
        addr = 32'h44;
        @(negedge CLK);
        checks++;
        if (rstate !== BUSY) begin errors++; $display("FAIL accchg_state got=%b exp=%b", rstate, BUSY); end
        next_cycle();
        wen = 1'b0; store = 32'h0;
        @(negedge CLK);
        checks++;
        if (rstate !== FREE) begin errors++; $display("FAIL accchg_free got=%b exp=%b", rstate, FREE); end
        next_cycle();
        read_word(32'h88, d, st);
        checks++;
        if (d !== 32'h2222_0088) begin errors++; $display("FAIL accchg_word88 got=%h exp=22220088", d); end
        read_word(32'h44, d, st);
        checks++;
        if (d !== 32'h1111_0044) begin errors++; $display("FAIL accchg_word44 got=%h exp=11110044", d); end
    endtask

    task automatic test_error();
        logic [31:0] d;
        logic [1:0]  st;
        logic [1:0]  exp_st;
        write_word(32'h0, 32'h0000_AAAA);
        ren = 1'b1; wen = 1'b1; addr = 32'h10;
        @(negedge CLK);
        checks++;
        if (rstate !== ERROR) begin errors++; $display("FAIL err_both got=%b exp=%b", rstate, ERROR); end
        checks++;
        if (load !== 32'h0) begin errors++; $display("FAIL err_both_load got=%h exp=0", load); end
        next_cycle();
        ren = 1'b0; wen = 1'b0;
        @(negedge CLK);
        checks++;
        if (rstate !== FREE) begin errors++; $display("FAIL err_clear got=%b exp=%b", rstate, FREE); end
        next_cycle();
        wen = 1'b1; addr = 32'h0001_0000; store = 32'hFFFF_FFFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            checks++;
            if (rstate !== ERROR) begin errors++; $display("FAIL err_range cyc=%0d got=%b exp=%b", c, rstate, ERROR); end
            next_cycle();
        end
        wen = 1'b0; store = 32'h0;
        ren = 1'b1; addr = 32'h0001_0004;
        @(negedge CLK);
        checks++;
        if (rstate !== ERROR || load !== 32'h0) begin errors++; $display("FAIL err_range_rd got=%b/%h exp=%b/0", rstate, load, ERROR); end
        next_cycle();
        ren = 1'b0;
        read_word(32'h0, d, st);
        checks++;
        if (d !== 32'h0000_AAAA) begin errors++; $display("FAIL err_alias got=%h exp=0000aaaa", d); end
        // error raised during WAIT sends the block back to idle; access restarts
        ren = 1'b1; addr = 32'h10;
        next_cycle();
        wen = 1'b1;
        @(negedge CLK);
        checks++;
        if (rstate !== ERROR) begin errors++; $display("FAIL err_midwait got=%b exp=%b", rstate, ERROR); end
        next_cycle();
        wen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            exp_st = (c == 3) ? ACCESS : BUSY;
            checks++;
            if (rstate !== exp_st) begin errors++; $display("FAIL err_restart cyc=%0d got=%b exp=%b", c, rstate, exp_st); end
            next_cycle();
        end
        ren = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_st;
        ren = 1'b1; addr = 32'hF0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            exp_st = (c == 3 || c == 7) ? ACCESS : BUSY;
            checks++;
            if (rstate !== exp_st) begin errors++; $display("FAIL b2b_state cyc=%0d got=%b exp=%b", c, rstate, exp_st); end
            checks++;
            if (load !== ((exp_st == ACCESS) ? 32'hDAD1DAD1 : 32'h0)) begin errors++; $display("FAIL b2b_load cyc=%0d got=%h", c, load); end
            next_cycle();
        end
        ren = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d;
        logic [1:0]  st;
        write_word(32'h40, 32'hCAFE_F00D);
        wen = 1'b1; addr = 32'h40; store = 32'h1234_5678;
        repeat (2) next_cycle();
        nRST = 1'b0;
        @(negedge CLK);
        checks++;
        if (rstate !== BUSY) begin errors++; $display("FAIL rstwr_inreset got=%b exp=%b", rstate, BUSY); end
        next_cycle();
        nRST = 1'b1;
        @(negedge CLK);
        checks++;
        if (rstate !== BUSY) begin errors++; $display("FAIL rstwr_restart got=%b exp=%b", rstate, BUSY); end
        next_cycle();
        wen = 1'b0; store = 32'h0;
        @(negedge CLK);
        checks++;
        if (rstate !== FREE) begin errors++; $display("FAIL rstwr_drop got=%b exp=%b", rstate, FREE); end
        next_cycle();
        read_word(32'h40, d, st);
        checks++;
        if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL rstwr_nowrite got=%h exp=cafef00d", d); end
    endtask

    task automatic test_lat0();
        logic [1:0] exp_st;
        wen0 = 1'b1; addr0 = 32'h40; store0 = 32'h5A5A_0040;
        @(negedge CLK);
        checks++;
        if (rstate0 !== BUSY) begin errors++; $display("FAIL lat0_wr_c0 got=%b exp=%b", rstate0, BUSY); end
        next_cycle();
        @(negedge CLK);
        checks++;
        if (rstate0 !== ACCESS) begin errors++; $display("FAIL lat0_wr_c1 got=%b exp=%b", rstate0, ACCESS); end
        next_cycle();
        wen0 = 1'b0; store0 = 32'h0;
        ren0 = 1'b1; addr0 = 32'h43;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            exp_st = (c % 2 == 1) ? ACCESS : BUSY;
            checks++;
            if (rstate0 !== exp_st) begin errors++; $display("FAIL lat0_rd_state cyc=%0d got=%b exp=%b", c, rstate0, exp_st); end
            checks++;
            if (load0 !== ((c % 2 == 1) ? 32'h5A5A_0040 : 32'h0)) begin errors++; $display("FAIL lat0_rd_load cyc=%0d got=%h", c, load0); end
            next_cycle();
        end
        ren0 = 1'b0;
        // reset lands in the ACCESS cycle of a write: nothing may be stored
        wen0 = 1'b1; addr0 = 32'h40; store0 = 32'h0BAD_0BAD;
        next_cycle();
        nRST = 1'b0;
        @(negedge CLK);
        checks++;
        if (rstate0 !== BUSY) begin errors++; $display("FAIL lat0_rst_acc got=%b exp=%b", rstate0, BUSY); end
        next_cycle();
        wen0 = 1'b0; store0 = 32'h0; nRST = 1'b1;
        @(negedge CLK);
        checks++;
        if (rstate0 !== FREE) begin errors++; $display("FAIL lat0_rst_free got=%b exp=%b", rstate0, FREE); end
        next_cycle();
        ren0 = 1'b1; addr0 = 32'h40;
        next_cycle();
        @(negedge CLK);
        checks++;
        if (rstate0 !== ACCESS || load0 !== 32'h5A5A_0040) begin
            errors++; $display("FAIL lat0_rst_nowrite got=%b/%h exp=%b/5a5a0040", rstate0, load0, ACCESS);
        end
        next_cycle();
        ren0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_offset();
        test_restart();
        test_drop();
        test_acc_change();
        test_error();
        test_back_to_back();
        test_reset_mid_write();
        test_lat0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
